// File: rtl/led_pattern_seq.sv
// LED pattern generator for the iCEstick output stage: four ring patterns
// stepped by a prescaler on D1-D4, and a triangle-modulated PWM "breathing" D5.
module led_pattern_seq #(
  parameter int TICK_DIV = 1200000,
  parameter int PWM_BITS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       pause,
  output logic [4:0] led,
  output logic       tick
);

  localparam int PRES_W = $clog2(TICK_DIV);
  localparam logic [PRES_W-1:0] PRES_MAX = PRES_W'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

  localparam logic [1:0] MODE_ALL_ON = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  logic [1:0]          mode_q, mode_d;
  logic [PRES_W-1:0]   pres_q, pres_d;
  logic                tick_q, tick_d;
  logic [1:0]          pos_q, pos_d;
  logic [0:0]          dir_q, dir_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          ring_q, ring_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] lvl_q, lvl_d;
  logic [0:0]          lvlDir_q, lvlDir_d;
  logic                breath_q, breath_d;

  // Mode change restarts the pattern and the prescaler phase, and outranks pause.
  always_comb begin
    mode_d = mode;
    pres_d = pres_q;
    tick_d = 1'b0;
    pos_d  = pos_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    if (mode != mode_q) begin
      pres_d = '0;
      pos_d  = 2'd0;
      dir_d  = DIR_UP;
      cnt_d  = 4'd0;
    end else if (!pause) begin
      if (pres_q == PRES_MAX) begin
        pres_d = '0;
        tick_d = 1'b1;
        case (mode_q)
          MODE_ROTATE: pos_d = pos_q + 2'd1;
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              pos_d = pos_q + 2'd1;
              if (pos_q == 2'd2) dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q - 2'd1;
              if (pos_q == 2'd1) dir_d = DIR_UP;
            end
          end
          MODE_COUNT:  cnt_d = cnt_q + 4'd1;
          default:     ;
        endcase
      end else begin
        pres_d = pres_q + PRES_W'(1);
      end
    end
  end

  // Ring decode reads the registered state, so the LEDs trail the pattern by a clock.
  always_comb begin
    ring_d = 4'b1111;
    case (mode_q)
      MODE_ALL_ON: ring_d = 4'b1111;
      MODE_ROTATE,
      MODE_BOUNCE: ring_d = 4'b0001 << pos_q;
      MODE_COUNT:  ring_d = cnt_q;
      default:     ring_d = 4'b1111;
    endcase
  end

  // Brightness walks a triangle, one step per PWM wrap, turning at both ends without dwell.
  always_comb begin
    pwm_d    = pwm_q + PWM_BITS'(1);
    lvl_d    = lvl_q;
    lvlDir_d = lvlDir_q;
    if (pwm_q == LVL_MAX) begin
      if (lvlDir_q == DIR_UP) begin
        lvl_d = lvl_q + PWM_BITS'(1);
        if (lvl_q == LVL_MAX - PWM_BITS'(1)) lvlDir_d = DIR_DOWN;
      end else begin
        lvl_d = lvl_q - PWM_BITS'(1);
        if (lvl_q == PWM_BITS'(1)) lvlDir_d = DIR_UP;
      end
    end
    breath_d = (pwm_q < lvl_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_ALL_ON;
      pres_q   <= '0;
      tick_q   <= 1'b0;
      pos_q    <= 2'd0;
      dir_q    <= DIR_UP;
      cnt_q    <= 4'd0;
      ring_q   <= 4'd0;
      pwm_q    <= '0;
      lvl_q    <= '0;
      lvlDir_q <= DIR_UP;
      breath_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      pres_q   <= pres_d;
      tick_q   <= tick_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      ring_q   <= ring_d;
      pwm_q    <= pwm_d;
      lvl_q    <= lvl_d;
      lvlDir_q <= lvlDir_d;
      breath_q <= breath_d;
    end
  end

  assign led  = {breath_q, ring_q};
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with TICK_DIV=4, PWM_BITS=3: tick/ring scoreboard
// plus a per-PWM-period duty checker for the breathing LED.
module tb_led_pattern_seq;

  typedef struct {
    int         cyc;
    logic [3:0] ring;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       pause;
  logic [4:0] led;
  logic       tick;

  int   cyc = 0;
  int   testsRun = 0;
  int   failCount = 0;
  exp_t expQ[$];

  led_pattern_seq #(.TICK_DIV(4), .PWM_BITS(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .pause(pause),
    .led  (led),
    .tick (tick)
  );

  always #5 clk = ~clk;

  // Edge counter: at the falling edge after rising edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic expectTick(input int c, input logic [3:0] r);
    exp_t e;
    e.cyc  = c;
    e.ring = r;
    expQ.push_back(e);
  endtask

  // Drive inputs on a falling edge and hold them until the requested cycle.
  task automatic applyStimulus(input logic [1:0] m, input logic p, input int untilCyc);
    mode  = m;
    pause = p;
    while (cyc < untilCyc) @(negedge clk);
  endtask

  function automatic int triLvl(input int j);
    int m;
    m = j % 14;
    return (m <= 7) ? m : 14 - m;
  endfunction

  // Scoreboard monitor: each tick pops an expectation; ring value checked one cycle later.
  initial begin : ringMonitor
    exp_t       e;
    logic       pending;
    logic [3:0] pendRing;
    pending  = 1'b0;
    pendRing = 4'd0;
    forever begin
      @(negedge clk);
      if (pending) begin
        checkOutput("ringAfterTick", {28'd0, led[3:0]}, {28'd0, pendRing});
        pending = 1'b0;
      end
      if (tick === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedTick", cyc, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("tickCycle", cyc, e.cyc);
          pendRing = e.ring;
          pending  = 1'b1;
        end
      end
    end
  end

  // Breathing checker: high count in each 8-cycle PWM window equals the triangle level.
  initial begin : breathMonitor
    int hi;
    int win;
    hi  = 0;
    win = 0;
    forever begin
      @(negedge clk);
      if (cyc >= 4) begin
        if (led[4] === 1'b1) hi++;
        if (((cyc - 4) % 8) == 7) begin
          checkOutput("breathDuty", hi, triLvl(win));
          win++;
          hi = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int pauseHigh;
    rst   = 1'b1;
    mode  = 2'd1;
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("resetLed", {27'd0, led}, 32'd0);
      checkOutput("resetTick", {31'd0, tick}, 32'd0);
    end
    rst = 1'b0;

    // ROTATE from reset release
    expectTick(8, 4'b0010);
    expectTick(12, 4'b0100);
    expectTick(16, 4'b1000);
    expectTick(20, 4'b0001);
    expectTick(24, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    checkOutput("releaseRing", {28'd0, led[3:0]}, 32'h1);
    applyStimulus(2'd1, 1'b0, 26);

    // Pause with pres=2 for ten cycles
    expectTick(38, 4'b0100);
    expectTick(42, 4'b1000);
    expectTick(46, 4'b0001);
    pause     = 1'b1;
    pauseHigh = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("pauseRing", {28'd0, led[3:0]}, 32'h2);
      checkOutput("pauseTick", {31'd0, tick}, 32'd0);
      if (led[4] === 1'b1) pauseHigh++;
    end
    checkOutput("pauseBreathToggles", {31'd0, (pauseHigh > 0 && pauseHigh < 10)}, 32'd1);
    applyStimulus(2'd1, 1'b0, 48);

    // BOUNCE
    expectTick(53, 4'b0010);
    expectTick(57, 4'b0100);
    expectTick(61, 4'b1000);
    expectTick(65, 4'b0100);
    expectTick(69, 4'b0010);
    expectTick(73, 4'b0001);
    expectTick(77, 4'b0010);
    applyStimulus(2'd2, 1'b0, 50);
    checkOutput("bounceStart", {28'd0, led[3:0]}, 32'h1);
    applyStimulus(2'd2, 1'b0, 78);

    // COUNT through a full wrap and on to cnt=5
    for (int k = 1; k <= 21; k++) begin
      logic [4:0] kv;
      kv = 5'(k);
      expectTick(79 + 4 * k, kv[3:0]);
    end
    applyStimulus(2'd3, 1'b0, 80);
    checkOutput("countStart", {28'd0, led[3:0]}, 32'h0);
    applyStimulus(2'd3, 1'b0, 166);

    // Mode change to ROTATE in the cycle where pres==3
    expectTick(171, 4'b0010);
    expectTick(175, 4'b0100);
    mode = 2'd1;
    @(negedge clk);
    checkOutput("changeNoTick", {31'd0, tick}, 32'd0);
    checkOutput("changeOldRing", {28'd0, led[3:0]}, 32'h5);
    @(negedge clk);
    checkOutput("changeRing", {28'd0, led[3:0]}, 32'h1);
    applyStimulus(2'd1, 1'b0, 178);

    #1;
    checkOutput("missingTicks", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
